// File: rtl/sc_stream_accum.sv
// sc_stream_accum -- stochastic-to-binary converter.
//
// Counts the ones in a stochastic bitstream (the divider quotient) over a
// programmable window of valid samples and presents the count on a
// valid/ready result port.
//
// Ports:
//   clk      in   clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   start    in   begin a new window (accepted only when the block can take one)
//   len      in   window length minus one, latched on an accepted start
//   bit_in   in   stochastic bit
//   bit_vld  in   qualifies bit_in
//   out_cnt  out  number of ones in the completed window (CNT_W+1 bits)
//   out_len  out  len belonging to out_cnt
//   out_vld  out  result valid, held stable until out_rdy
//   out_rdy  in   consumer accepts the result on out_vld && out_rdy
//   busy     out  high while a window is being counted
//
// Optional feature macro: SC_ACCUM_OVERLAP_EN
//   When defined, a new window may start while the previous result is still
//   waiting; a second completed result parks in a shadow register.
module sc_stream_accum #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic [CNT_W:0]   out_cnt,
    output logic [CNT_W-1:0] out_len,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_RUN_HOLD,
        S_FULL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W:0]   smp_q, smp_d;
    logic [CNT_W:0]   one_q, one_d;
    logic [CNT_W:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] out_len_q, out_len_d;
    logic             out_vld_q, out_vld_d;
    logic             busy_q, busy_d;
`ifdef SC_ACCUM_OVERLAP_EN
    logic [CNT_W:0]   shd_cnt_q, shd_cnt_d;
    logic [CNT_W-1:0] shd_len_q, shd_len_d;
`endif

    logic [CNT_W:0] smp_inc;
    logic [CNT_W:0] one_inc;
    logic [CNT_W:0] win_tgt;
    logic           last;
    logic           hs;

    // Sample counter is one bit wider than len so a 2^CNT_W window compares
    // without wrap; the target is len+1 valid samples.
    assign smp_inc = smp_q + (CNT_W+1)'(1);
    assign one_inc = one_q + (CNT_W+1)'(bit_in);
    assign win_tgt = {1'b0, len_q} + (CNT_W+1)'(1);
    assign last    = bit_vld && (smp_inc == win_tgt);
    assign hs      = out_vld_q && out_rdy;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        smp_d     = smp_q;
        one_d     = one_q;
        out_cnt_d = out_cnt_q;
        out_len_d = out_len_q;
        out_vld_d = out_vld_q;
`ifdef SC_ACCUM_OVERLAP_EN
        shd_cnt_d = shd_cnt_q;
        shd_len_d = shd_len_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    smp_d   = '0;
                    one_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bit_vld) begin
                    smp_d = smp_inc;
                    one_d = one_inc;
                    if (last) begin
                        out_vld_d = 1'b1;
                        out_cnt_d = one_inc;
                        out_len_d = len_q;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (hs) begin
                    out_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
`ifdef SC_ACCUM_OVERLAP_EN
                // A window may open behind the waiting result; if that result
                // leaves in the same cycle the block is simply running.
                if (start) begin
                    len_d   = len;
                    smp_d   = '0;
                    one_d   = '0;
                    state_d = hs ? S_RUN : S_RUN_HOLD;
                end
`endif
            end
`ifdef SC_ACCUM_OVERLAP_EN
            S_RUN_HOLD: begin
                if (bit_vld) begin
                    smp_d = smp_inc;
                    one_d = one_inc;
                end
                if (last) begin
                    if (hs) begin
                        // Old result leaves as the new one lands: no shadow use.
                        out_cnt_d = one_inc;
                        out_len_d = len_q;
                        state_d   = S_HOLD;
                    end else begin
                        shd_cnt_d = one_inc;
                        shd_len_d = len_q;
                        state_d   = S_FULL;
                    end
                end else if (hs) begin
                    out_vld_d = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_FULL: begin
                if (hs) begin
                    out_cnt_d = shd_cnt_q;
                    out_len_d = shd_len_q;
                    state_d   = S_HOLD;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_RUN_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            smp_q     <= '0;
            one_q     <= '0;
            out_cnt_q <= '0;
            out_len_q <= '0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SC_ACCUM_OVERLAP_EN
            shd_cnt_q <= '0;
            shd_len_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            smp_q     <= smp_d;
            one_q     <= one_d;
            out_cnt_q <= out_cnt_d;
            out_len_q <= out_len_d;
            out_vld_q <= out_vld_d;
            busy_q    <= busy_d;
`ifdef SC_ACCUM_OVERLAP_EN
            shd_cnt_q <= shd_cnt_d;
            shd_len_q <= shd_len_d;
`endif
        end
    end

    assign out_cnt = out_cnt_q;
    assign out_len = out_len_q;
    assign out_vld = out_vld_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sc_stream_accum.sv
// Testbench for sc_stream_accum: directed windows checked every cycle
// against a queue-based model, plus literal expectations at key points.
module tb_sc_stream_accum;

    localparam int CNT_W = 8;
`ifdef SC_ACCUM_OVERLAP_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             bit_in = 1'b0;
    logic             bit_vld = 1'b0;
    logic [CNT_W:0]   out_cnt;
    logic [CNT_W-1:0] out_len;
    logic             out_vld;
    logic             out_rdy = 1'b0;
    logic             busy;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sc_stream_accum #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .bit_in(bit_in), .bit_vld(bit_vld),
        .out_cnt(out_cnt), .out_len(out_len), .out_vld(out_vld),
        .out_rdy(out_rdy), .busy(busy)
    );

    // Model: an open window collects its valid bits; finished windows form a
    // FIFO of results of depth CAP, whose head is what the outputs show.
    bit win_active = 1'b0;
    int win_len = 0;
    bit win_bits[$];
    int res_cnt[$];
    int res_len[$];

    always @(posedge clk) begin
        int  pre_size;
        bit  accept;
        bit  done;
        int  sum;
        if (rst) begin
            win_active = 1'b0;
            win_bits.delete();
            res_cnt.delete();
            res_len.delete();
        end else begin
            pre_size = res_cnt.size();
            accept   = !win_active && start && (pre_size < CAP);
            done     = 1'b0;
            sum      = 0;
            if (win_active && bit_vld) begin
                win_bits.push_back(bit_in);
                if (win_bits.size() == win_len + 1) begin
                    foreach (win_bits[i]) sum += int'(win_bits[i]);
                    done = 1'b1;
                end
            end
            if (pre_size > 0 && out_rdy) begin
                void'(res_cnt.pop_front());
                void'(res_len.pop_front());
            end
            if (done) begin
                res_cnt.push_back(sum);
                res_len.push_back(win_len);
                win_active = 1'b0;
            end else if (accept) begin
                win_active = 1'b1;
                win_len    = int'(len);
                win_bits.delete();
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model out_vld", 32'(out_vld), 32'(res_cnt.size() > 0));
            chk("model busy", 32'(busy), 32'(win_active));
            if (res_cnt.size() > 0) begin
                chk("model out_cnt", 32'(out_cnt), 32'(res_cnt[0]));
                chk("model out_len", 32'(out_len), 32'(res_len[0]));
            end
        end
    end

    // One cycle of inputs, applied just after a negedge.
    task automatic step(input logic s, input logic [CNT_W-1:0] l, input logic b,
                        input logic v, input logic r);
        start   = s;
        len     = l;
        bit_in  = b;
        bit_vld = v;
        out_rdy = r;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;

        // Reset
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("reset out_vld", 32'(out_vld), 0);
        chk("reset out_cnt", 32'(out_cnt), 0);
        chk("reset out_len", 32'(out_len), 0);
        chk("reset busy", 32'(busy), 0);
        chk_en = 1'b1;

        // 1: len=7, bits 1,0,1,1,0,0,1,0
        pat = 8'b0100_1101;
        step(1, 7, 0, 0, 1);
        chk("t1 busy", 32'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, pat[i], 1, 1);
            if (i == 6) chk("t1 vld early", 32'(out_vld), 0);
        end
        chk("t1 out_vld", 32'(out_vld), 1);
        chk("t1 out_cnt", 32'(out_cnt), 4);
        chk("t1 out_len", 32'(out_len), 7);
        chk("t1 busy done", 32'(busy), 0);
        step(0, 0, 0, 0, 1);
        chk("t1 pulse", 32'(out_vld), 0);

        // 2: 256-sample windows, all ones then all zeros
        step(1, 255, 0, 0, 1);
        for (int i = 0; i < 256; i++) step(0, 0, 1, 1, 1);
        chk("t2 ones vld", 32'(out_vld), 1);
        chk("t2 ones cnt", 32'(out_cnt), 256);
        chk("t2 ones len", 32'(out_len), 255);
        step(0, 0, 0, 0, 1);
        step(1, 255, 0, 0, 1);
        for (int i = 0; i < 256; i++) step(0, 0, 0, 1, 1);
        chk("t2 zeros vld", 32'(out_vld), 1);
        chk("t2 zeros cnt", 32'(out_cnt), 0);
        step(0, 0, 0, 0, 1);

        // 3: len=3, bit_vld toggles, bit_in=1
        step(1, 3, 1, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, (i % 2 == 0), 1);
            if (i == 5) chk("t3 vld early", 32'(out_vld), 0);
            if (i == 6) begin
                chk("t3 out_vld", 32'(out_vld), 1);
                chk("t3 out_cnt", 32'(out_cnt), 4);
            end
        end
        chk("t3 vld gone", 32'(out_vld), 0);

        // 4: result held for 10 cycles with out_rdy=0
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            chk("t4 held vld", 32'(out_vld), 1);
            chk("t4 held cnt", 32'(out_cnt), 1);
`ifdef SC_ACCUM_OVERLAP_EN
            step(0, 0, 1, 1, 0);
`else
            step(i == 3, 9, 1, 1, 0);
            chk("t4 start ignored", 32'(busy), 0);
`endif
        end
        step(0, 0, 0, 0, 1);
        chk("t4 released", 32'(out_vld), 0);

        // 5: reset mid-window, then a fresh 2-sample window
        step(1, 9, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1);
        rst = 1'b1;
        step(1, 0, 1, 1, 1);
        rst = 1'b0;
        chk("t5 rst vld", 32'(out_vld), 0);
        chk("t5 rst cnt", 32'(out_cnt), 0);
        chk("t5 rst len", 32'(out_len), 0);
        chk("t5 rst busy", 32'(busy), 0);
        step(1, 1, 0, 0, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        chk("t5 out_vld", 32'(out_vld), 1);
        chk("t5 out_cnt", 32'(out_cnt), 2);
        step(0, 0, 0, 0, 1);

`ifdef SC_ACCUM_OVERLAP_EN
        // 6: overlapped windows through the shadow register
        step(1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        chk("t6 A cnt", 32'(out_cnt), 3);
        step(1, 1, 0, 0, 0);
        chk("t6 B busy", 32'(busy), 1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("t6 full busy", 32'(busy), 0);
        chk("t6 full cnt", 32'(out_cnt), 3);
        step(1, 0, 1, 1, 0);
        chk("t6 full start ign", 32'(busy), 0);
        step(0, 0, 0, 0, 1);
        chk("t6 B vld", 32'(out_vld), 1);
        chk("t6 B cnt", 32'(out_cnt), 2);
        chk("t6 B len", 32'(out_len), 1);
        // Completion and handshake in the same cycle
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1);
        chk("t6 C vld", 32'(out_vld), 1);
        chk("t6 C cnt", 32'(out_cnt), 1);
        chk("t6 C len", 32'(out_len), 0);
        step(0, 0, 0, 0, 1);
        chk("t6 drained", 32'(out_vld), 0);
`endif

        step(0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
